// File: rtl/ps2_rx.sv
// PS/2 device-to-host line receiver: synchronizes and deglitches the pins, deframes 11-bit frames,
// checks odd parity and stop bit. Optional scan-code prefix folding under `PS2_RX_PREFIX_EN.
module ps2_rx #(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic       busy,
    output logic       extended,
    output logic       released
);

    localparam int TMO_LIMIT = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    localparam int FILT_W    = $clog2(FILTER_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] bits_v, input logic par_v);
        return (^bits_v) ^ par_v;
    endfunction

    logic                  clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic [FILT_W-1:0]     filt_cnt_r;
    logic                  filt_clk_r, filt_prev_r;
    logic [FILTER_LEN-1:0] dat_dly_r;
    state_t                state_r, state_nxt_s;
    logic [2:0]            bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]            sr_r, sr_nxt_s;
    logic                  par_r, par_nxt_s;
    logic [TMO_W-1:0]      tmo_cnt_r, tmo_nxt_s;
    logic                  good_s, bad_s, sample_s, sample_dat_s;
`ifdef PS2_RX_PREFIX_EN
    logic                  ext_pend_r, rel_pend_r;
`endif

    // Two-flop synchronizers on both raw pins
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Clock deglitch filter; data is delayed by the same depth so it lines up with the filtered edge
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_r  <= '0;
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
            dat_dly_r   <= '1;
        end else begin
            filt_prev_r <= filt_clk_r;
            dat_dly_r   <= {dat_dly_r[FILTER_LEN-2:0], dat_sync_r};
            if (clk_sync_r != filt_clk_r) begin
                if (filt_cnt_r == FILT_W'(FILTER_LEN - 1)) begin
                    filt_clk_r <= clk_sync_r;
                    filt_cnt_r <= '0;
                end else begin
                    filt_cnt_r <= filt_cnt_r + FILT_W'(1);
                end
            end else begin
                filt_cnt_r <= '0;
            end
        end
    end

    assign sample_s     = filt_prev_r & ~filt_clk_r;
    assign sample_dat_s = dat_dly_r[FILTER_LEN-1];

    // Frame FSM next-state; a sample event takes priority over the inter-edge timeout
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        sr_nxt_s      = sr_r;
        par_nxt_s     = par_r;
        tmo_nxt_s     = tmo_cnt_r;
        good_s        = 1'b0;
        bad_s         = 1'b0;
        if (sample_s) begin
            tmo_nxt_s = '0;
            case (state_r)
                IDLE: begin
                    if (!sample_dat_s) begin
                        state_nxt_s   = DATA;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                DATA: begin
                    sr_nxt_s = {sample_dat_s, sr_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = PARITY;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    par_nxt_s   = sample_dat_s;
                    state_nxt_s = STOP;
                end
                STOP: begin
                    state_nxt_s = IDLE;
                    if (odd_parity_ok(sr_r, par_r) && sample_dat_s) begin
                        good_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else if (state_r != IDLE) begin
            if (tmo_cnt_r == TMO_W'(TMO_LIMIT - 1)) begin
                bad_s         = 1'b1;
                state_nxt_s   = IDLE;
                bit_cnt_nxt_s = 3'd0;
                tmo_nxt_s     = '0;
            end else begin
                tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
            end
        end else begin
            tmo_nxt_s = '0;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            sr_r      <= 8'h00;
            par_r     <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            sr_r      <= sr_nxt_s;
            par_r     <= par_nxt_s;
            tmo_cnt_r <= tmo_nxt_s;
        end
    end

    // Registered outputs and prefix tracking
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            data     <= 8'h00;
            valid    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            extended <= 1'b0;
            released <= 1'b0;
`ifdef PS2_RX_PREFIX_EN
            ext_pend_r <= 1'b0;
            rel_pend_r <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            error <= bad_s;
            busy  <= (state_nxt_s != IDLE);
`ifdef PS2_RX_PREFIX_EN
            if (bad_s) begin
                ext_pend_r <= 1'b0;
                rel_pend_r <= 1'b0;
            end else if (good_s) begin
                if (sr_r == 8'hE0) begin
                    ext_pend_r <= 1'b1;
                end else if (sr_r == 8'hF0) begin
                    rel_pend_r <= 1'b1;
                end else begin
                    valid      <= 1'b1;
                    data       <= sr_r;
                    extended   <= ext_pend_r;
                    released   <= rel_pend_r;
                    ext_pend_r <= 1'b0;
                    rel_pend_r <= 1'b0;
                end
            end else begin
                ext_pend_r <= ext_pend_r;
            end
`else
            extended <= 1'b0;
            released <= 1'b0;
            if (good_s) begin
                valid <= 1'b1;
                data  <= sr_r;
            end else begin
                data <= data;
            end
`endif
        end
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 line receiver. Sits directly upstream of the ps2 keyboard/joystick decoder in the zx_ula top, in the clk28 domain.
- Takes the raw asynchronous ps2_clk and ps2_dat pins, synchronizes them, removes glitches, deframes the 11-bit device-to-host frames and checks parity and stop bit.
- Delivers each received scan-code byte to the decoder with a one-cycle strobe. Reports framing errors and timeouts with a separate strobe.

Parameters:
- CLK_FREQ, 28_000_000: system clock frequency in Hz. Used to size the timeout counter.
- FILTER_LEN, 8: number of consecutive identical synchronized samples needed before the filtered PS/2 clock changes level.
- TIMEOUT_US, 200: maximum gap in microseconds between PS/2 clock falling edges inside a frame.

Ports:
- clk28, input, 1: system clock. All logic is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ps2_clk_in, input, 1: raw PS/2 clock pin, asynchronous.
- ps2_dat_in, input, 1: raw PS/2 data pin, asynchronous.
- data, output, 8: last good byte received.
- valid, output, 1: one-cycle strobe; data is new.
- error, output, 1: one-cycle strobe on parity error, stop-bit error, start-bit error or timeout.
- busy, output, 1: high while a frame is in progress.
- extended, output, 1: flag qualified by valid; the byte followed an E0 prefix.
- released, output, 1: flag qualified by valid; the byte followed an F0 prefix.

Behaviour:
- Interface fixed: one clock, clk28; rst_n is asynchronous, active-low.
- Reset values: data=0x00, valid=0, error=0, busy=0, extended=0, released=0. FSM in IDLE, filtered clock=1, synchronizers=1, prefix flags cleared.
- Input conditioning:
  - Two-flop synchronizer on each input.
  - Filtered clock goes 0 only after FILTER_LEN consecutive synchronized 0 samples, and 1 only after FILTER_LEN consecutive 1 samples.
  - A falling edge of the filtered clock is the sample event. On that cycle the synchronized data value is taken, delayed to align with the clock path.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on sample events, except timeout.
  - IDLE: on data=0 go to DATA with bit counter=0. On data=1, pulse error and stay in IDLE.
  - DATA: shift the bit in LSB first (sr <= {bit, sr[7:1]}). After the 8th bit go to PARITY.
  - PARITY: store the bit. Parity is good when XOR of sr[7:0] and the parity bit equals 1 (odd parity). Go to STOP.
  - STOP: if parity is good and the stop bit is 1, load data and pulse valid. Otherwise pulse error and leave data unchanged. Return to IDLE.
- Timing of strobes:
  - valid/error assert for exactly one cycle, in the cycle after the stop-bit sample event.
  - data is stable from that cycle until the next valid.
- busy = (state != IDLE). It is registered and falls in the same cycle valid/error rises.
- Timeout:
  - Counter clears on every sample event and runs while not in IDLE.
  - When it reaches CLK_FREQ/1_000_000*TIMEOUT_US, pulse error, return to IDLE, and clear the bit counter.
  - Width is $clog2 of the limit.
  - If a sample event and the timeout occur in the same cycle, the sample event wins.
- Reset mid-frame aborts immediately. No valid or error is produced.
- Without PS2_RX_PREFIX_EN, extended and released are constant 0.

Optional Feature:
- Macro: PS2_RX_PREFIX_EN.
- When defined:
  - A good byte 0xE0 sets ext_pending; a good byte 0xF0 sets rel_pending. Neither produces valid, and data is not updated.
  - The next good non-prefix byte pulses valid with extended=ext_pending and released=rel_pending. Both pending flags then clear.
  - Any error strobe clears both pending flags.
  - 0xE1 is passed through as an ordinary byte.
- When not defined: every good byte, prefixes included, pulses valid, and extended/released stay 0.

Test Plan:
- Bench timing: device clock 12.5 kHz (40 us half-periods), data changes mid-high phase.
- Frame 0x1C with parity bit 0 and stop bit 1 -> exactly one valid pulse, data=0x1C, error never asserted, busy low after the frame.
- Frame 0x1C with parity bit 1 -> one error pulse, no valid, data keeps its previous value 0x1C (from the prior test).
- Frame 0x5A with correct parity and stop bit 0 -> one error pulse, no valid. The following good frame 0x29 -> valid, data=0x29.
- Start bit plus 4 data bits, then clock idle for 250 us -> error pulse about 200 us after the last falling edge, busy drops. The next frame 0x76 decodes correctly.
- While idle, a 3-cycle low glitch on ps2_clk_in (shorter than FILTER_LEN) -> no state change, busy=0, no strobes. Async rst_n asserted mid-frame -> all outputs return to reset values, no strobe.
- Frames E0, F0, 75:
  - With PS2_RX_PREFIX_EN: a single valid, data=0x75, extended=1, released=1. A following 0x75 frame gives valid with both flags 0.
  - Without the macro: three valids with data E0, F0, 75, flags 0.
